alu_secuenciador: RTL

//  Upstream controller for the 4-bit ALU operations stage. Accepts one instruction

---
 rtl/alu_secuenciador.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_secuenciador.sv
// Upstream sequencer for the 4-bit ALU: latches one host instruction, drives init/rd around done,
// and returns the captured result. Define ALU_SEQ_TIMEOUT_EN to enable the WAIT_DONE timeout/error.
module alu_secuenciador #(
  parameter int unsigned EXEC_CYCLES = 2
`ifdef ALU_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr_in,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  output logic       busy,
  output logic [3:0] result,
  output logic       result_valid,
  output logic       error,
  output logic [7:0] instr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       init,
  output logic       rd,
  input  logic       done,
  input  logic [3:0] dato_mux
);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntMax = (EXEC_CYCLES > TIMEOUT) ? EXEC_CYCLES : TIMEOUT;
`else
  localparam int unsigned CntMax = EXEC_CYCLES;
`endif
  localparam int unsigned CntW = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
  // The ALU has no readback path for this opcode; the result is operand A.
  localparam logic [2:0] OpNoRead = 3'h7;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StWaitDone,
    StRead,
    StSettle
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            init_q, init_d;
  logic            rd_q, rd_d;
  logic            rv_q, rv_d;
  logic [3:0]      result_q, result_d;
  logic [7:0]      instr_q, instr_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic            error_q, error_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    init_d   = 1'b0;
    rd_d     = 1'b0;
    rv_d     = 1'b0;
    result_d = result_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    error_d  = error_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          instr_d = instr_in;
          a_d     = A_in;
          b_d     = B_in;
          busy_d  = 1'b1;
          init_d  = 1'b1;
          cnt_d   = '0;
`ifdef ALU_SEQ_TIMEOUT_EN
          error_d = 1'b0;
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntW'(EXEC_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StWaitDone;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          init_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (done) begin
          if (instr_q[7:5] == OpNoRead) begin
            result_d = a_q;
            rv_d     = 1'b1;
            busy_d   = 1'b0;
            state_d  = StIdle;
          end else begin
            rd_d    = 1'b1;
            state_d = StRead;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StRead: begin
        state_d = StSettle;
      end
      StSettle: begin
        // dato_mux was loaded by the ALU on the rd edge and is stable now.
        result_d = dato_mux;
        rv_d     = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      init_q   <= 1'b0;
      rd_q     <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= 4'h0;
      instr_q  <= 8'h00;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
`ifdef ALU_SEQ_TIMEOUT_EN
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      init_q   <= init_d;
      rd_q     <= rd_d;
      rv_q     <= rv_d;
      result_q <= result_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      error_q  <= error_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign init         = init_q;
  assign rd           = rd_q;
  assign result_valid = rv_q;
  assign result       = result_q;
  assign instr        = instr_q;
  assign A            = a_q;
  assign B            = b_q;
`ifdef ALU_SEQ_TIMEOUT_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule
